// File: rtl/branch_pred_unit_pkg.sv
// Shared opcode definitions and branch-table constants for the branch resolution unit.
// Holds the instruction/register types, RISC-V control-flow opcode fields and the
// control-flow classification used between resolution and the target table.
package branch_pred_unit_pkg;

  typedef logic [31:0] instruction_t;
  typedef logic [31:0] register_t;

  // Major opcode field instr[6:0]
  localparam logic [6:0] M_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] M_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] M_OPC_BRANCH = 7'b1100011;

  // Conditional branch funct3 field instr[14:12]
  localparam logic [2:0] M_F3_BEQ  = 3'b000;
  localparam logic [2:0] M_F3_BNE  = 3'b001;
  localparam logic [2:0] M_F3_BLT  = 3'b100;
  localparam logic [2:0] M_F3_BGE  = 3'b101;
  localparam logic [2:0] M_F3_BLTU = 3'b110;
  localparam logic [2:0] M_F3_BGEU = 3'b111;

  typedef enum logic [1:0] {CfNone, CfJal, CfJalr, CfBranch} cf_kind_e;

  // Weakly-taken counter value (MSB set, rest clear) for a counter of the given width;
  // callers truncate to their own counter width.
  function automatic logic [31:0] bp_ctr_weak_taken(int unsigned bits);
    return 32'(1) << (bits - 1);
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Direct-mapped tagged branch target table with saturating direction counters.
// Lookup is combinational from the flops; updates land on the clock edge; flush
// clears every valid bit and takes priority over a coincident update.
module branch_bht
  import branch_pred_unit_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 16,
  parameter int unsigned CTR_BITS    = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_branch_i,
  input  logic            upd_jal_i,
  input  logic            upd_jalr_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int unsigned IDX_BITS = $clog2(BHT_ENTRIES);
  localparam int unsigned TAG_BITS = XLEN - IDX_BITS - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] BP_CTR_WEAK_TAKEN = CTR_BITS'(bp_ctr_weak_taken(CTR_BITS));

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [XLEN-1:0]     target;
    logic [CTR_BITS-1:0] ctr;
  } bp_entry_t;

  bp_entry_t           table_q [BHT_ENTRIES];
  logic [IDX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0] u_tag;
  bp_entry_t           f_entry, u_entry, wr_entry_d;
  logic                u_hit, wr_en_d;

  // Word-offset bits never participate in indexing or tagging
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc_i[1:0], upd_pc_i[1:0]};

  // Fetch-side lookup straight from the table flops
  always_comb begin
    f_idx         = fetch_pc_i[IDX_BITS+1:2];
    f_entry       = table_q[f_idx];
    pred_taken_o  = f_entry.valid && (f_entry.tag == fetch_pc_i[XLEN-1:IDX_BITS+2]) &&
                    f_entry.ctr[CTR_BITS-1];
    pred_target_o = f_entry.target;
  end

  // Next contents of the entry addressed by the resolving instruction
  always_comb begin
    u_idx      = upd_pc_i[IDX_BITS+1:2];
    u_tag      = upd_pc_i[XLEN-1:IDX_BITS+2];
    u_entry    = table_q[u_idx];
    u_hit      = u_entry.valid && (u_entry.tag == u_tag);
    wr_en_d    = 1'b0;
    wr_entry_d = u_entry;
    if (upd_branch_i) begin
      if (u_hit) begin
        wr_en_d           = 1'b1;
        wr_entry_d.target = upd_target_i;
        if (upd_taken_i) begin
          if (u_entry.ctr != CTR_MAX) wr_entry_d.ctr = u_entry.ctr + CTR_BITS'(1);
        end else begin
          if (u_entry.ctr != '0) wr_entry_d.ctr = u_entry.ctr - CTR_BITS'(1);
        end
      end else if (upd_taken_i) begin
        wr_en_d           = 1'b1;
        wr_entry_d.valid  = 1'b1;
        wr_entry_d.tag    = u_tag;
        wr_entry_d.target = upd_target_i;
        wr_entry_d.ctr    = BP_CTR_WEAK_TAKEN;
      end
    end else if (upd_jal_i) begin
      wr_en_d           = 1'b1;
      wr_entry_d.valid  = 1'b1;
      wr_entry_d.tag    = u_tag;
      wr_entry_d.target = upd_target_i;
      wr_entry_d.ctr    = CTR_MAX;
    end else if (upd_jalr_i && u_hit) begin
      // Indirect targets are not cached; drop any stale entry for this PC
      wr_en_d          = 1'b1;
      wr_entry_d.valid = 1'b0;
    end
  end

  // Table storage: reset clears everything, flush clears only valid bits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) table_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) table_q[i].valid <= 1'b0;
    end else if (wr_en_d) begin
      table_q[u_idx] <= wr_entry_d;
    end
  end

endmodule

// File: rtl/branch_pred_unit.sv
// Execute-stage control-flow resolution with a fetch-side branch target table.
// Produces the registered next PC, link address and mispredict flag.
// Optional feature macro: BRANCH_PERF_EN adds resolve/mispredict event counters.
module branch_pred_unit
  import branch_pred_unit_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     BHT_ENTRIES = 16,
  parameter int unsigned     CTR_BITS    = 2,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [XLEN-1:0] op3,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pred_pc,
  input  logic            enable,
  input  logic            step,
  input  logic            flush,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] ret_addr,
  output logic            mispredict
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  cf_kind_e        kind;
  logic            br_taken;
  logic [XLEN-1:0] pc4, br_tgt, next_pc;
  logic [XLEN-1:0] pc_out_q, pc_out_d, ret_addr_q, ret_addr_d;
  logic            mispredict_q, mispredict_d;
  logic            resolve;

  // Only opcode and funct3 matter for control-flow classification
  logic unused_instr;
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  assign resolve = step && enable;

  // Classify the instruction and evaluate the branch condition
  always_comb begin
    kind     = CfNone;
    br_taken = 1'b0;
    unique case (instr[6:0])
      M_OPC_JAL:  kind = CfJal;
      M_OPC_JALR: kind = CfJalr;
      M_OPC_BRANCH: begin
        kind = CfBranch;
        unique case (instr[14:12])
          M_F3_BEQ:  br_taken = (op1 == op2);
          M_F3_BNE:  br_taken = (op1 != op2);
          M_F3_BLT:  br_taken = ($signed(op1) < $signed(op2));
          M_F3_BGE:  br_taken = ($signed(op1) >= $signed(op2));
          M_F3_BLTU: br_taken = (op1 < op2);
          M_F3_BGEU: br_taken = (op1 >= op2);
          default:   kind = CfNone;
        endcase
      end
      default: kind = CfNone;
    endcase
  end

  // Resolved next PC and next-state of the output registers
  always_comb begin
    pc4    = pc + XLEN'(4);
    br_tgt = pc + op3;
    unique case (kind)
      CfJal:    next_pc = op1;
      CfJalr:   next_pc = (op1 + op2) & ~XLEN'(1);
      CfBranch: next_pc = br_taken ? br_tgt : pc4;
      default:  next_pc = pc4;
    endcase
    pc_out_d     = pc_out_q;
    ret_addr_d   = ret_addr_q;
    mispredict_d = mispredict_q;
    if (step) begin
      if (enable) begin
        pc_out_d     = next_pc;
        ret_addr_d   = pc4;
        mispredict_d = (next_pc != pred_pc);
      end else begin
        pc_out_d     = pc4;
        mispredict_d = 1'b0;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out_q     <= RESET_PC;
      ret_addr_q   <= '0;
      mispredict_q <= 1'b0;
    end else begin
      pc_out_q     <= pc_out_d;
      ret_addr_q   <= ret_addr_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign pc_out     = pc_out_q;
  assign ret_addr   = ret_addr_q;
  assign mispredict = mispredict_q;

  branch_bht #(
    .XLEN        (XLEN),
    .BHT_ENTRIES (BHT_ENTRIES),
    .CTR_BITS    (CTR_BITS)
  ) u_bht (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .fetch_pc_i    (fetch_pc),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target),
    .upd_branch_i  (resolve && (kind == CfBranch)),
    .upd_jal_i     (resolve && (kind == CfJal)),
    .upd_jalr_i    (resolve && (kind == CfJalr)),
    .upd_taken_i   (br_taken),
    .upd_pc_i      (pc),
    .upd_target_i  ((kind == CfJal) ? op1 : br_tgt)
  );

`ifdef BRANCH_PERF_EN
  logic [31:0] perf_br_q, perf_br_d, perf_mp_q, perf_mp_d;

  // Event counters wrap naturally at 2^32
  always_comb begin
    perf_br_d = perf_br_q;
    perf_mp_d = perf_mp_q;
    if (resolve) begin
      perf_br_d = perf_br_q + 32'd1;
      if (mispredict_d) perf_mp_d = perf_mp_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;
`endif

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench for branch_pred_unit: directed scenarios then randomized
// resolves checked against a behavioural table/resolution model.
module tb_branch_pred_unit;

  localparam int unsigned ENT  = 16;
  localparam int unsigned IDXB = 4;
  localparam int unsigned CB   = 2;
  localparam logic [31:0] RST_PC = 32'h100;
  localparam logic [6:0] OPC_BR   = 7'h63;
  localparam logic [6:0] OPC_JAL  = 7'h6f;
  localparam logic [6:0] OPC_JALR = 7'h67;
  localparam logic [6:0] OPC_ALU  = 7'h33;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, op1, op2, op3, pc, pred_pc, fetch_pc;
  logic        enable, step, flush;
  logic        pred_taken, mispredict;
  logic [31:0] pred_target, pc_out, ret_addr;
`ifdef BRANCH_PERF_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_pred_unit #(
    .XLEN        (32),
    .BHT_ENTRIES (ENT),
    .CTR_BITS    (CB),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .op1         (op1),
    .op2         (op2),
    .op3         (op3),
    .pc          (pc),
    .pred_pc     (pred_pc),
    .enable      (enable),
    .step        (step),
    .flush       (flush),
    .fetch_pc    (fetch_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .pc_out      (pc_out),
    .ret_addr    (ret_addr),
    .mispredict  (mispredict)
`ifdef BRANCH_PERF_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: one record per table slot plus expected output registers
  bit          m_valid [ENT];
  logic [31:0] m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_ctr   [ENT];
  logic [31:0] e_pc_out, e_ret, e_pb, e_pm;
  logic        e_misp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
    e_pc_out = RST_PC; e_ret = '0; e_misp = 1'b0; e_pb = '0; e_pm = '0;
  endtask

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % ENT);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[slot(a)] && (m_tag[slot(a)] == (a >> (IDXB + 2)));
  endfunction

  // Resolve one instruction in the model; flush discards any table change
  task automatic model_step(input logic [6:0] opc, input logic [2:0] f3, input bit en,
                            input bit fl, input bit st);
    logic [31:0] pc4, nxt;
    bit          is_br, tk;
    int          s;
    pc4 = pc + 32'd4;
    s   = slot(pc);
    if (st && !en) begin
      e_pc_out = pc4;
      e_misp   = 1'b0;
    end else if (st) begin
      is_br = (opc == OPC_BR) && (f3 != 3'd2) && (f3 != 3'd3);
      tk = 0;
      if (is_br) begin
        case (f3)
          3'd0: tk = (op1 == op2);
          3'd1: tk = (op1 != op2);
          3'd4: tk = int'(op1) < int'(op2);
          3'd5: tk = int'(op1) >= int'(op2);
          3'd6: tk = longint'({32'd0, op1}) < longint'({32'd0, op2});
          default: tk = longint'({32'd0, op1}) >= longint'({32'd0, op2});
        endcase
      end
      if (opc == OPC_JAL) nxt = op1;
      else if (opc == OPC_JALR) nxt = {op1 + op2} & 32'hFFFF_FFFE;
      else if (is_br) nxt = tk ? pc + op3 : pc4;
      else nxt = pc4;
      e_ret = pc4; e_pc_out = nxt; e_misp = (nxt != pred_pc);
      e_pb++;
      if (e_misp) e_pm++;
      if (!fl) begin
        if (is_br && m_hit(pc)) begin
          m_tgt[s] = pc + op3;
          m_ctr[s] = tk ? ((m_ctr[s] < (1 << CB) - 1) ? m_ctr[s] + 1 : m_ctr[s])
                        : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
        end else if (is_br && tk) begin
          m_valid[s] = 1; m_tag[s] = pc >> (IDXB + 2); m_tgt[s] = pc + op3;
          m_ctr[s] = 1 << (CB - 1);
        end else if (opc == OPC_JAL) begin
          m_valid[s] = 1; m_tag[s] = pc >> (IDXB + 2); m_tgt[s] = op1;
          m_ctr[s] = (1 << CB) - 1;
        end else if (opc == OPC_JALR && m_hit(pc)) begin
          m_valid[s] = 0;
        end
      end
    end
    if (fl) for (int i = 0; i < ENT; i++) m_valid[i] = 0;
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] opc, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom();
    return {r[31:15], f3, r[11:7], opc};
  endfunction

  task automatic check_regs(input string tag);
    check({tag, "_pc_out"}, pc_out, e_pc_out);
    check({tag, "_ret_addr"}, ret_addr, e_ret);
    check({tag, "_mispredict"}, {31'd0, mispredict}, {31'd0, e_misp});
`ifdef BRANCH_PERF_EN
    check({tag, "_perf_br"}, perf_branches, e_pb);
    check({tag, "_perf_mp"}, perf_mispredicts, e_pm);
`endif
  endtask

  // Drive one cycle at the falling edge, then check registered outputs after the rise
  task automatic do_step(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                         input bit en, input bit fl, input bit st, input logic [31:0] a_pc,
                         input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3,
                         input logic [31:0] a_pred);
    @(negedge clk);
    pc = a_pc; op1 = a1; op2 = a2; op3 = a3; pred_pc = a_pred;
    instr = mk_instr(opc, f3); enable = en; flush = fl; step = st;
    model_step(opc, f3, en, fl, st);
    @(posedge clk);
    #1;
    step = 1'b0; enable = 1'b0; flush = 1'b0;
    check_regs(tag);
  endtask

  task automatic look(input string tag, input logic [31:0] a);
    bit exp_tk;
    fetch_pc = a;
    #1;
    exp_tk = m_hit(a) && (m_ctr[slot(a)] >= (1 << (CB - 1)));
    check({tag, "_pred_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
    if (exp_tk) check({tag, "_pred_target"}, pred_target, m_tgt[slot(a)]);
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [31:0] pick_pc();
    logic [31:0] t, i;
    t = 32'($urandom_range(0, 3));
    i = 32'($urandom_range(0, ENT - 1));
    return (t << (IDXB + 2)) | (i << 2);
  endfunction

  initial begin
    logic [31:0] rpc, ra, rb, rc, rp;
    logic [6:0]  ropc;
    logic [2:0]  rf3;
    int          sel;

    rst = 1'b0; instr = '0; op1 = '0; op2 = '0; op3 = '0; pc = '0; pred_pc = '0;
    fetch_pc = '0; enable = 1'b0; step = 1'b0; flush = 1'b0;
    model_reset();
    #2 rst = 1'b1;
    #1;
    check_regs("reset");
    look("reset_0x40", 32'h40);
    look("reset_0x100", 32'h100);
    @(negedge clk);
    rst = 1'b0;

    // Taken BEQ allocates weakly-taken
    do_step("beq_t", OPC_BR, 3'd0, 1, 0, 1, 32'h40, 32'd5, 32'd5, 32'h20, 32'h44);
    check("beq_t_pc_const", pc_out, 32'h60);
    look("beq_t_look", 32'h40);
    // Two not-taken resolves walk the counter down; one taken leaves it below threshold
    do_step("beq_n1", OPC_BR, 3'd0, 1, 0, 1, 32'h40, 32'd5, 32'd6, 32'h20, 32'h44);
    look("beq_n1_look", 32'h40);
    do_step("beq_n2", OPC_BR, 3'd0, 1, 0, 1, 32'h40, 32'd5, 32'd6, 32'h20, 32'h44);
    look("beq_n2_look", 32'h40);
    do_step("beq_t2", OPC_BR, 3'd0, 1, 0, 1, 32'h40, 32'd5, 32'd5, 32'h20, 32'h60);
    look("beq_t2_look", 32'h40);
    // Signed vs unsigned compare of the same operands
    do_step("blt", OPC_BR, 3'd4, 1, 0, 1, 32'h80, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h84);
    check("blt_pc_const", pc_out, 32'h90);
    look("blt_look", 32'h80);
    do_step("bltu", OPC_BR, 3'd6, 1, 0, 1, 32'h84, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h88);
    check("bltu_pc_const", pc_out, 32'h88);
    // JAL allocates strongly taken; JALR at the same PC invalidates it
    do_step("jal", OPC_JAL, 3'd0, 1, 0, 1, 32'h200, 32'h300, 32'd0, 32'd0, 32'h300);
    look("jal_look", 32'h200);
    do_step("jalr", OPC_JALR, 3'd0, 1, 0, 1, 32'h200, 32'h1001, 32'h4, 32'd0, 32'h204);
    check("jalr_pc_const", pc_out, 32'h1004);
    look("jalr_look", 32'h200);
    // Flush beats a coincident allocation
    do_step("flush", OPC_BR, 3'd1, 1, 1, 1, 32'h48, 32'd1, 32'd2, 32'h8, 32'h4C);
    look("flush_0x48", 32'h48);
    look("flush_0x80", 32'h80);
    // Non-control-flow step, then a held cycle
    do_step("noen", OPC_BR, 3'd0, 0, 0, 1, 32'h500, 32'd3, 32'd3, 32'h40, 32'h0);
    do_step("hold", OPC_JAL, 3'd0, 1, 0, 0, 32'h600, 32'h700, 32'd0, 32'd0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      rf3 = 3'($urandom_range(0, 7));
      if (sel <= 4) ropc = OPC_BR;
      else if (sel <= 6) ropc = OPC_JAL;
      else if (sel == 7) ropc = OPC_JALR;
      else ropc = OPC_ALU;
      rpc = pick_pc(); ra = pick_op(); rb = pick_op();
      rc = 32'($urandom_range(0, 63)) << 2;
      if (ropc == OPC_JAL) ra = pick_pc();
      rp = ($urandom_range(0, 1) == 0) ? rpc + 32'd4 : rpc + rc;
      do_step("rnd", ropc, rf3, $urandom_range(0, 7) != 0, $urandom_range(0, 29) == 0,
              $urandom_range(0, 9) != 0, rpc, ra, rb, rc, rp);
      look("rnd_self", rpc);
      look("rnd_other", pick_pc());
    end

    // Asynchronous reset in the middle of a resolve cycle
    do_step("pre_rst", OPC_JAL, 3'd0, 1, 0, 1, 32'h44, 32'h88, 32'd0, 32'd0, 32'h0);
    @(negedge clk);
    pc = 32'h40; op1 = 32'd7; op2 = 32'd7; op3 = 32'h20; pred_pc = 32'h0;
    instr = mk_instr(OPC_BR, 3'd0); enable = 1'b1; step = 1'b1;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_regs("async_rst");
    look("async_rst_look", 32'h44);
    @(posedge clk);
    #1;
    check_regs("rst_over_edge");
    step = 1'b0; enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    look("post_rst_0x40", 32'h40);
    do_step("post_rst", OPC_BR, 3'd0, 1, 0, 1, 32'h40, 32'd7, 32'd7, 32'h20, 32'h60);
    look("post_rst_look", 32'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
